// File: rtl/mcs4_clk_rst_seq.sv
// mcs4_clk_rst_seq: two-phase clock enables, 8-subcycle machine-cycle sequencer and core reset stretcher.
// Defining MCS4_CLK_HALT_EN adds a debug halt that freezes the clocks after X3.
module mcs4_clk_rst_seq #(
    parameter int PHASE_DIV = 2,
    parameter int CLR_HOLD  = 16
) (
    input  logic       sysclk,
    input  logic       poc_pad,
    input  logic       clear_pad,
    input  logic       halt_req,
    output logic       phi1,
    output logic       phi2,
    output logic [2:0] cycle_state,
    output logic       cycle_start,
    output logic       sync_out,
    output logic       core_reset,
    output logic       halted
);
    localparam int DW = PHASE_DIV > 1 ? $clog2(PHASE_DIV) : 1;
    localparam int HW = $clog2(CLR_HOLD);
    localparam logic [DW-1:0] DIV_MAX  = DW'(PHASE_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(CLR_HOLD - 1);

    typedef enum logic [1:0] {HOLD, RUN, HALT} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    slot_q, slot_d;
    logic [2:0]    cyc_q, cyc_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          clr_m_q, clr_s_q;
    logic          div_wrap, boundary, freeze;

    assign div_wrap = div_q == DIV_MAX;
    assign boundary = slot_q == 2'd3 && div_wrap;

`ifdef MCS4_CLK_HALT_EN
    // Phase counters stop on the X3-ending boundary and stay there while halted.
    assign freeze = halt_req && !clr_s_q &&
                    ((state_q == RUN && boundary && cyc_q == 3'd7) || state_q == HALT);
    assign halted = state_q == HALT;
`else
    assign freeze = 1'b0;
    assign halted = 1'b0;
`endif

    assign div_d  = freeze ? div_q : (div_wrap ? '0 : div_q + 1'b1);
    assign slot_d = (freeze || !div_wrap) ? slot_q : slot_q + 2'd1;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        hold_d  = hold_q;
        case (state_q)
            HOLD: begin
                cyc_d  = 3'd7;
                hold_d = clr_s_q ? '0 : (hold_q == HOLD_MAX ? hold_q : hold_q + 1'b1);
                if (hold_q == HOLD_MAX && boundary && !clr_s_q) begin
                    state_d = RUN;
                    cyc_d   = 3'd0;
                end
            end
            RUN: begin
                if (clr_s_q) begin
                    state_d = HOLD;
                    hold_d  = '0;
                    cyc_d   = 3'd7;
                end else if (freeze) begin
                    state_d = HALT;
                end else if (boundary) begin
                    cyc_d = cyc_q + 3'd1;
                end
            end
            HALT: begin
                if (clr_s_q) begin
                    state_d = HOLD;
                    hold_d  = '0;
                    cyc_d   = 3'd7;
                end else if (!halt_req) begin
                    state_d = RUN;
                    cyc_d   = 3'd0;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (poc_pad) begin
            state_q <= HOLD;
            div_q   <= DIV_MAX;
            slot_q  <= 2'd3;
            cyc_q   <= 3'd7;
            hold_q  <= '0;
            clr_m_q <= 1'b0;
            clr_s_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            slot_q  <= slot_d;
            cyc_q   <= cyc_d;
            hold_q  <= hold_d;
            clr_m_q <= clear_pad;
            clr_s_q <= clr_m_q;
        end
    end

    assign phi1        = state_q != HALT && slot_q == 2'd0;
    assign phi2        = state_q != HALT && slot_q == 2'd2;
    assign cycle_state = cyc_q;
    assign cycle_start = state_q == RUN && cyc_q == 3'd0 && slot_q == 2'd0 && div_q == '0;
    assign sync_out    = state_q == RUN && cyc_q == 3'd7;
    assign core_reset  = state_q == HOLD;
endmodule

// File: tb/tb_mcs4_clk_rst_seq.sv
// tb_mcs4_clk_rst_seq: scoreboard bench for the MCS-4 clock/reset sequencer (default PHASE_DIV=2, CLR_HOLD=16).
module tb_mcs4_clk_rst_seq;
    logic       sysclk = 1'b0;
    logic       poc_pad = 1'b1;
    logic       clear_pad = 1'b0;
    logic       halt_req = 1'b0;
    logic       phi1, phi2, cycle_start, sync_out, core_reset, halted;
    logic [2:0] cycle_state;
    int         n_checks = 0;
    int         n_fail = 0;

    typedef struct packed {
        logic       rst;
        logic       p1;
        logic       p2;
        logic       st;
        logic       sy;
        logic [2:0] cs;
    } exp_t;

    mcs4_clk_rst_seq dut (
        .sysclk(sysclk), .poc_pad(poc_pad), .clear_pad(clear_pad), .halt_req(halt_req),
        .phi1(phi1), .phi2(phi2), .cycle_state(cycle_state), .cycle_start(cycle_start),
        .sync_out(sync_out), .core_reset(core_reset), .halted(halted)
    );

    always #5 sysclk = ~sysclk;

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic test_reset();
        logic want[$];
        logic w;
        poc_pad = 1'b1;
        tick(5);
        n_checks++;
        if ({core_reset, phi1, phi2, cycle_start, sync_out, halted} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_outputs: got rst,p1,p2,st,sy,hlt=%b want 100000",
                     {core_reset, phi1, phi2, cycle_start, sync_out, halted});
        end
        n_checks++;
        if (cycle_state !== 3'd7) begin
            n_fail++;
            $display("FAIL reset_cycle_state: got %0d want 7", cycle_state);
        end
        poc_pad = 1'b0;
        for (int k = 1; k <= 17; k++) want.push_back(k < 17);
        for (int k = 1; k <= 17; k++) begin
            tick(1);
            w = want.pop_front();
            n_checks++;
            if (core_reset !== w) begin
                n_fail++;
                $display("FAIL release_core_reset edge %0d: got %b want %b", k, core_reset, w);
            end
        end
        n_checks++;
        if ({phi1, cycle_start, cycle_state} !== {1'b1, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL release_first_a1: got phi1=%b start=%b cs=%0d want 1 1 0", phi1, cycle_start, cycle_state);
        end
    endtask

    task automatic test_phase();
        exp_t q[$];
        exp_t e, o;
        int   sync_cnt = 0;
        int   start_cnt = 0;
        for (int i = 0; i < 192; i++) begin
            e.rst = 1'b0;
            e.p1  = (i % 8) < 2;
            e.p2  = (i % 8) == 4 || (i % 8) == 5;
            e.cs  = 3'((i / 8) % 8);
            e.sy  = e.cs == 3'd7;
            e.st  = (i % 64) == 0;
            q.push_back(e);
        end
        for (int i = 0; i < 192; i++) begin
            e = q.pop_front();
            o = {core_reset, phi1, phi2, cycle_start, sync_out, cycle_state};
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL phase_pattern i=%0d: got %b want %b", i, o, e);
            end
            n_checks++;
            if (phi1 && phi2) begin
                n_fail++;
                $display("FAIL phase_overlap i=%0d: got phi1&phi2=1 want 0", i);
            end
            sync_cnt += int'(sync_out);
            start_cnt += int'(cycle_start);
            if (i % 64 == 63) begin
                n_checks++;
                if (sync_cnt != 8) begin
                    n_fail++;
                    $display("FAIL sync_width i=%0d: got %0d want 8", i, sync_cnt);
                end
                sync_cnt = 0;
            end
            tick(1);
        end
        n_checks++;
        if (start_cnt != 3) begin
            n_fail++;
            $display("FAIL cycle_start_count: got %0d want 3", start_cnt);
        end
    endtask

    task automatic test_clear_pulse();
        logic want[$];
        logic w;
        tick(28);
        n_checks++;
        if (cycle_state !== 3'd3) begin
            n_fail++;
            $display("FAIL pulse_setup_m1: got %0d want 3", cycle_state);
        end
        clear_pad = 1'b1;
        for (int j = 0; j < 20; j++) want.push_back(j >= 2 && j <= 18);
        tick(1);
        clear_pad = 1'b0;
        for (int j = 0; j < 20; j++) begin
            if (j > 0) tick(1);
            w = want.pop_front();
            n_checks++;
            if (core_reset !== w) begin
                n_fail++;
                $display("FAIL pulse_core_reset edge a+%0d: got %b want %b", j, core_reset, w);
            end
            if (j == 2) begin
                n_checks++;
                if (cycle_state !== 3'd7) begin
                    n_fail++;
                    $display("FAIL pulse_abort_state: got %0d want 7", cycle_state);
                end
            end
        end
        n_checks++;
        if ({phi1, cycle_start, cycle_state} !== {1'b1, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL pulse_resume_a1: got phi1=%b start=%b cs=%0d want 1 1 0", phi1, cycle_start, cycle_state);
        end
    endtask

    task automatic test_clear_long();
        int  cnt = 0;
        bit  fell = 0;
        clear_pad = 1'b1;
        for (int j = 1; j <= 100; j++) begin
            tick(1);
            if (j >= 3) begin
                n_checks++;
                if (core_reset !== 1'b1 || cycle_state !== 3'd7) begin
                    n_fail++;
                    $display("FAIL long_clear_hold j=%0d: got rst=%b cs=%0d want 1 7", j, core_reset, cycle_state);
                end
            end
        end
        clear_pad = 1'b0;
        for (int j = 0; j < 40 && !fell; j++) begin
            tick(1);
            if (core_reset) cnt++;
            else fell = 1;
        end
        n_checks++;
        if (!fell || cnt < 16 || cnt > 26) begin
            n_fail++;
            $display("FAIL long_clear_release: got fell=%0d held=%0d want fell=1 held 16..26", fell, cnt);
        end
        n_checks++;
        if ({phi1, cycle_start, cycle_state} !== {1'b1, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL long_clear_exit_a1: got phi1=%b start=%b cs=%0d want 1 1 0", phi1, cycle_start, cycle_state);
        end
    endtask

`ifdef MCS4_CLK_HALT_EN
    task automatic test_halt();
        logic want[$];
        logic w;
        tick(32);
        n_checks++;
        if (cycle_state !== 3'd4) begin
            n_fail++;
            $display("FAIL halt_setup_m2: got %0d want 4", cycle_state);
        end
        halt_req = 1'b1;
        for (int j = 1; j <= 32; j++) want.push_back(j == 32);
        for (int j = 1; j <= 32; j++) begin
            tick(1);
            w = want.pop_front();
            n_checks++;
            if (halted !== w) begin
                n_fail++;
                $display("FAIL halt_entry edge %0d: got %b want %b", j, halted, w);
            end
        end
        for (int j = 0; j < 10; j++) begin
            n_checks++;
            if ({halted, phi1, phi2, sync_out, core_reset, cycle_state} !== {5'b10000, 3'd7}) begin
                n_fail++;
                $display("FAIL halt_frozen j=%0d: got hlt=%b p1=%b p2=%b sy=%b rst=%b cs=%0d want 1 0 0 0 0 7",
                         j, halted, phi1, phi2, sync_out, core_reset, cycle_state);
            end
            tick(1);
        end
        halt_req = 1'b0;
        tick(1);
        n_checks++;
        if ({halted, phi1, cycle_start, cycle_state} !== {3'b011, 3'd0}) begin
            n_fail++;
            $display("FAIL halt_exit: got hlt=%b p1=%b st=%b cs=%0d want 0 1 1 0", halted, phi1, cycle_start, cycle_state);
        end
    endtask
`else
    task automatic test_halt();
        tick(32);
        halt_req = 1'b1;
        for (int j = 1; j <= 64; j++) begin
            tick(1);
            n_checks++;
            if (halted !== 1'b0 || cycle_state !== 3'((4 + j / 8) % 8)) begin
                n_fail++;
                $display("FAIL halt_ignored j=%0d: got hlt=%b cs=%0d want 0 %0d", j, halted, cycle_state, (4 + j / 8) % 8);
            end
        end
        halt_req = 1'b0;
    endtask
`endif

    task automatic test_poc_override();
        clear_pad = 1'b1;
        halt_req  = 1'b1;
        tick(3);
        poc_pad = 1'b1;
        tick(1);
        n_checks++;
        if ({core_reset, phi1, phi2, halted, cycle_state} !== {4'b1000, 3'd7}) begin
            n_fail++;
            $display("FAIL poc_override: got rst=%b p1=%b p2=%b hlt=%b cs=%0d want 1 0 0 0 7",
                     core_reset, phi1, phi2, halted, cycle_state);
        end
        clear_pad = 1'b0;
        halt_req  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_phase();
        test_clear_pulse();
        test_clear_long();
        test_halt();
        test_poc_override();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
